// File: rtl/frontend_pkg.sv
// rtl/frontend_pkg.sv - shared sample type, framer state encoding and index-width helper
package frontend_pkg;

    typedef logic signed [11:0] sample_t;

    localparam int FRAC_BITS = 10;

    typedef enum logic {
        FILL,
        EMIT
    } fb_state_e;

    // One extra bit over the ring address so full and empty remain distinguishable.
    function automatic int idx_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// rtl/frame_buffer_if.sv - sample-in / frame-out stream bundle for frame_buffer
interface frame_buffer_if;
    import frontend_pkg::*;

    logic    in_valid;
    sample_t p;
    logic    out_valid;
    logic    out_ready;
    sample_t f;
    logic    sof;
    logic    eof;
    logic    ovr;

    modport master (
        output in_valid, p, out_ready,
        input  out_valid, f, sof, eof, ovr
    );

    modport slave (
        input  in_valid, p, out_ready,
        output out_valid, f, sof, eof, ovr
    );

endinterface

// File: rtl/ring_ram.sv
// rtl/ring_ram.sv - sample ring storage, one synchronous write port, one asynchronous read port
module ring_ram
    import frontend_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  sample_t       wdata_i,
    input  logic [AW-1:0] raddr_i,
    output sample_t       rdata_o
);

    sample_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - cuts a non-stallable sample stream into overlapping frames, emitted oldest first
module frame_buffer
    import frontend_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int HOP       = 4
) (
    input logic           clk,
    input logic           rst,
    frame_buffer_if.slave bus
);

    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int IW    = idx_width(DEPTH);
    localparam int AW    = IW - 1;
    localparam int KW    = $clog2(FRAME_LEN);

    localparam logic [IW-1:0] LEN_W   = IW'(FRAME_LEN);
    localparam logic [IW-1:0] DEPTH_W = IW'(DEPTH);
    localparam logic [IW-1:0] HOP_W   = IW'(HOP);
    localparam logic [KW-1:0] LAST_K  = KW'(FRAME_LEN - 1);

    if ((FRAME_LEN < 2) || ((FRAME_LEN & (FRAME_LEN - 1)) != 0)) begin : g_bad_frame_len
        $error("frame_buffer: FRAME_LEN must be a power of two >= 2");
    end
    if ((HOP < 1) || (HOP > FRAME_LEN)) begin : g_bad_hop
        $error("frame_buffer: HOP must lie in 1..FRAME_LEN");
    end

    fb_state_e     state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] base_idx_q, base_idx_d;
    logic [IW-1:0] fill, fill_nxt;
    logic [KW-1:0] rd_k_q, rd_k_d;
    logic [AW-1:0] rd_ptr;
    logic          wr_en, load;
    sample_t       rd_data;
    sample_t       f_q, f_d;
    logic          out_valid_q, out_valid_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic          ovr_q, ovr_d;

    assign fill     = wr_idx_q - base_idx_q;
    assign wr_en    = bus.in_valid && (fill != DEPTH_W);
    assign wr_idx_d = wr_idx_q + IW'(wr_en);
    assign ovr_d    = ovr_q || (bus.in_valid && (fill == DEPTH_W));
    assign load     = !out_valid_q || bus.out_ready;

    ring_ram #(.DEPTH(DEPTH)) u_ring (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_idx_q[AW-1:0]),
        .wdata_i (bus.p),
        .raddr_i (rd_ptr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        base_idx_d  = base_idx_q;
        rd_k_d      = rd_k_q;
        out_valid_d = out_valid_q;
        f_d         = f_q;
        sof_d       = sof_q;
        eof_d       = eof_q;
        fill_nxt    = fill;
        rd_ptr      = base_idx_q[AW-1:0] + AW'(rd_k_q);

        case (state_q)
            FILL: begin
                if ((fill >= LEN_W) && load) begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    f_d         = rd_data;
                    sof_d       = 1'b1;
                    eof_d       = 1'b0;
                    rd_k_d      = KW'(1);
                end
            end
            EMIT: begin
                if (out_valid_q && eof_q) begin
                    if (bus.out_ready) begin
                        // Next frame may start back-to-back; its fill counts this edge's write.
                        base_idx_d = base_idx_q + HOP_W;
                        fill_nxt   = wr_idx_d - base_idx_d;
                        if (fill_nxt >= LEN_W) begin
                            rd_ptr      = base_idx_d[AW-1:0];
                            out_valid_d = 1'b1;
                            f_d         = rd_data;
                            sof_d       = 1'b1;
                            eof_d       = 1'b0;
                            rd_k_d      = KW'(1);
                        end else begin
                            state_d     = FILL;
                            out_valid_d = 1'b0;
                            sof_d       = 1'b0;
                            eof_d       = 1'b0;
                            rd_k_d      = '0;
                        end
                    end
                end else if (load) begin
                    out_valid_d = 1'b1;
                    f_d         = rd_data;
                    sof_d       = (rd_k_q == '0);
                    eof_d       = (rd_k_q == LAST_K);
                    rd_k_d      = rd_k_q + 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            wr_idx_q    <= '0;
            base_idx_q  <= '0;
            rd_k_q      <= '0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            base_idx_q  <= base_idx_d;
            rd_k_q      <= rd_k_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.sof       = sof_q;
    assign bus.eof       = eof_q;
    assign bus.ovr       = ovr_q;

endmodule

// File: tb/tb_frame_buffer.sv
// tb/tb_frame_buffer.sv - directed self-checking bench for frame_buffer
module tb_frame_buffer;
    import frontend_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frame_buffer_if bus();

    frame_buffer #(.FRAME_LEN(8), .HOP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    sample_t got_f[$];
    logic    got_sof[$];
    logic    got_eof[$];

    sample_t exp_a [8] = '{12'sd64, 12'sd128, 12'sd192, 12'sd256,
                           12'sd320, 12'sd384, 12'sd448, -12'sd1024};
    sample_t exp_b [8] = '{12'sd320, 12'sd384, 12'sd448, -12'sd1024,
                           12'sd576, 12'sd640, 12'sd704, 12'sd768};

    task automatic tick();
        if (bus.out_valid && bus.out_ready) begin
            got_f.push_back(bus.f);
            got_sof.push_back(bus.sof);
            got_eof.push_back(bus.eof);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_f.delete();
        got_sof.delete();
        got_eof.delete();
    endtask

    task automatic collect(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while ((got_f.size() < n) && (c < budget)) begin
            tick();
            c++;
        end
        ok = (got_f.size() >= n);
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.p         = '0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = i[0];
            bus.out_ready = i[1];
            bus.p         = sample_t'(i * 100 + 7);
            tick();
            n_checks++;
            if ({bus.out_valid, bus.sof, bus.eof, bus.ovr} !== 4'b0000 || bus.f !== 12'sd0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: out_valid=%b sof=%b eof=%b ovr=%b f=%0d, required all zero",
                         i, bus.out_valid, bus.sof, bus.eof, bus.ovr, bus.f);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
    endtask

    task automatic test_first_frame();
        bit      early;
        bit      ok;
        sample_t act;
        early = 1'b0;
        clear_got();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.p        = exp_a[i];
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            if (i < 7) begin
                if (bus.out_valid) early = 1'b1;
                tick();
                if (bus.out_valid) early = 1'b1;
            end
        end
        n_checks++;
        if (early !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_no_early: early=%b out_valid=%b after 8th write, required 0 0", early, bus.out_valid);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.f !== 12'sd64 || bus.sof !== 1'b1) begin
            n_fail++;
            $display("FAIL first_latency: out_valid=%b f=%0d sof=%b, required 1 64 1", bus.out_valid, bus.f, bus.sof);
        end
        collect(8, 30, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL first_timeout: got %0d words, required 8", got_f.size());
        end
        for (int i = 0; i < 8; i++) begin
            act = (i < got_f.size()) ? got_f[i] : 'x;
            n_checks++;
            if (act !== exp_a[i] || (i < got_f.size() && (got_sof[i] !== (i == 0) || got_eof[i] !== (i == 7)))) begin
                n_fail++;
                $display("FAIL first_word %0d: f=%0d, required %0d (sof/eof on words 0/7)", i, act, exp_a[i]);
            end
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_idle_after_eof: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_hop();
        bit      early;
        bit      ok;
        sample_t act;
        early = 1'b0;
        clear_got();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.p        = exp_b[4 + i];
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            if (bus.out_valid) early = 1'b1;
            if (i < 3) begin
                tick();
                if (bus.out_valid) early = 1'b1;
            end
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL hop_no_early: output seen before 12th write, required none");
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.f !== 12'sd320 || bus.sof !== 1'b1) begin
            n_fail++;
            $display("FAIL hop_first_word: out_valid=%b f=%0d sof=%b, required 1 320 1", bus.out_valid, bus.f, bus.sof);
        end
        collect(8, 30, ok);
        for (int i = 0; i < 8; i++) begin
            act = (i < got_f.size()) ? got_f[i] : 'x;
            n_checks++;
            if (act !== exp_b[i] || (i < got_f.size() && (got_sof[i] !== (i == 0) || got_eof[i] !== (i == 7)))) begin
                n_fail++;
                $display("FAIL hop_word %0d: f=%0d, required %0d (sof/eof on words 0/7)", i, act, exp_b[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit      pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit      stall_bad;
        bit      bubble;
        bit      pre_v;
        bit      rdy;
        sample_t pre_f;
        sample_t act;
        sample_t want;
        int      k;
        stall_bad = 1'b0;
        bubble    = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_got();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.p        = (i < 8) ? exp_a[i] : exp_b[i - 4];
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.f !== 12'sd64 || bus.ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_held_first: out_valid=%b f=%0d ovr=%b, required 1 64 0", bus.out_valid, bus.f, bus.ovr);
        end
        k = 0;
        while ((got_f.size() < 16) && (k < 200)) begin
            rdy           = pat[k % 6];
            bus.out_ready = rdy;
            pre_v         = bus.out_valid;
            pre_f         = bus.f;
            tick();
            if (pre_v && !rdy && bus.f !== pre_f) stall_bad = 1'b1;
            if ((got_f.size() < 16) && !bus.out_valid) bubble = 1'b1;
            k++;
        end
        n_checks++;
        if (stall_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall_stable: f changed while stalled, required stable");
        end
        n_checks++;
        if (bubble !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_bubble: out_valid dropped between frames, required continuous");
        end
        for (int i = 0; i < 16; i++) begin
            act  = (i < got_f.size()) ? got_f[i] : 'x;
            want = (i < 8) ? exp_a[i] : exp_b[i - 8];
            n_checks++;
            if (act !== want || (i < got_f.size() && (got_sof[i] !== (i % 8 == 0) || got_eof[i] !== (i % 8 == 7)))) begin
                n_fail++;
                $display("FAIL bp_word %0d: f=%0d, required %0d", i, act, want);
            end
        end
        n_checks++;
        if (bus.ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ovr: ovr=%b, required 0", bus.ovr);
        end
    endtask

    task automatic test_overrun();
        bit      ok;
        sample_t act;
        sample_t want;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_got();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            bus.p        = sample_t'(i * 64);
            bus.in_valid = 1'b1;
            tick();
            if (i == 16) begin
                n_checks++;
                if (bus.ovr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovr_at_full: ovr=%b after 16 writes, required 0", bus.ovr);
                end
            end
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: ovr=%b after 17th write, required 1", bus.ovr);
        end
        bus.out_ready = 1'b1;
        collect(24, 80, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovr_timeout: got %0d words, required 24", got_f.size());
        end
        for (int i = 0; i < 24; i++) begin
            act  = (i < got_f.size()) ? got_f[i] : 'x;
            want = sample_t'(((i / 8) * 4 + (i % 8) + 1) * 64);
            n_checks++;
            if (act !== want || (i < got_f.size() && (got_sof[i] !== (i % 8 == 0) || got_eof[i] !== (i % 8 == 7)))) begin
                n_fail++;
                $display("FAIL ovr_word %0d: f=%0d, required %0d", i, act, want);
            end
        end
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (got_f.size() != 24 || bus.out_valid !== 1'b0 || bus.ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_tail: words=%0d out_valid=%b ovr=%b, required 24 0 1", got_f.size(), bus.out_valid, bus.ovr);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit      ok;
        sample_t act;
        sample_t want;
        clear_got();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.p        = sample_t'(i * 11);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        collect(3, 20, ok);
        for (int i = 0; i < 3; i++) begin
            act  = (i < got_f.size()) ? got_f[i] : 'x;
            want = sample_t'((13 + i) * 64);
            n_checks++;
            if (act !== want) begin
                n_fail++;
                $display("FAIL mid_pre_word %0d: f=%0d, required %0d", i, act, want);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.sof, bus.eof, bus.ovr} !== 4'b0000 || bus.f !== 12'sd0) begin
            n_fail++;
            $display("FAIL mid_async_reset: out_valid=%b sof=%b eof=%b ovr=%b f=%0d, required all zero",
                     bus.out_valid, bus.sof, bus.eof, bus.ovr, bus.f);
        end
        tick();
        tick();
        rst = 1'b1;
        clear_got();
        for (int i = 1; i <= 8; i++) begin
            bus.p        = sample_t'(i * 100);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        collect(8, 30, ok);
        for (int i = 0; i < 8; i++) begin
            act  = (i < got_f.size()) ? got_f[i] : 'x;
            want = sample_t'((i + 1) * 100);
            n_checks++;
            if (act !== want || (i < got_f.size() && (got_sof[i] !== (i == 0) || got_eof[i] !== (i == 7)))) begin
                n_fail++;
                $display("FAIL mid_fresh_word %0d: f=%0d, required %0d", i, act, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_hop();
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the summary, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
